lpif_ll_tx_gearbox_x8_asym2: RTL and testbench

//  Logic-link TX stage directly downstream of the x8 asym2 quarter-rate LPIF packer.

---
 rtl/lpif_ll_pkg.sv | 14 +
 rtl/lpif_ll_sync_fifo.sv | 71 +++++++
 rtl/lpif_ll_tx_gearbox_x8_asym2.sv | 165 ++++++++++++++++
 tb/tb_lpif_ll_tx_gearbox_x8_asym2.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpif_ll_pkg.sv
// Shared definitions for the logic-link TX path: word/half-word widths and the
// gearbox state encoding.
package lpif_ll_pkg;

  localparam int LL_WORD_W = 580;
  localparam int LL_HALF_W = LL_WORD_W / 2;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_LO  = 2'd1,
    ST_HI  = 2'd2
  } ll_gb_state_t;

endpackage

// File: rtl/lpif_ll_sync_fifo.sv
// Single-clock show-ahead word FIFO. The head entry is always visible on
// 'head'. Occupancy is a separate counter, so a full FIFO (count == DEPTH) is
// distinguishable from an empty one even though the pointers wrap.
module lpif_ll_sync_fifo
  import lpif_ll_pkg::*;
#(
  parameter int WIDTH = LL_WORD_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // A push into a full FIFO is dropped even if a pop happens on the same edge.
  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage: cleared on reset so the head never presents undefined data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/lpif_ll_tx_gearbox_x8_asym2.sv
// Logic-link TX stage: buffers packed 580-bit words and emits each as two
// registered 290-bit beats (low half first, mark=1) toward the PHY adapter.
// Transmission starts only while the link is online; a word whose low half has
// gone out always completes its high half, even if the link drops meanwhile.
module lpif_ll_tx_gearbox_x8_asym2
  import lpif_ll_pkg::*;
#(
  parameter int DATA_W     = LL_WORD_W,
  parameter int FIFO_DEPTH = 8,
  parameter int AFULL_LVL  = 6
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr_n,
  input  logic                          tx_online,
  input  logic [DATA_W-1:0]             txfifo_downstream_data,
  input  logic                          txfifo_downstream_valid,
  output logic                          txfifo_downstream_ready,
  output logic                          tx_fifo_afull,
  output logic [$clog2(FIFO_DEPTH):0]   tx_fifo_count,
  output logic [DATA_W/2-1:0]           tx_phy_data,
  output logic                          tx_phy_valid,
  output logic                          tx_phy_mark,
  output logic                          tx_overflow
);

  localparam int HALF_W = DATA_W / 2;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  ll_gb_state_t      state_r;
  ll_gb_state_t      next_state_s;
  logic              push_s;
  logic              pop_s;
  logic [DATA_W-1:0] head_s;
  logic [CW-1:0]     count_s;
  logic              full_s;
  logic              empty_s;
  logic [HALF_W-1:0] data_nxt_s;
  logic              valid_nxt_s;
  logic              mark_nxt_s;
  logic [HALF_W-1:0] data_r;
  logic              valid_r;
  logic              mark_r;
  logic              overflow_r;

  // Ready is judged on the pre-pop count, so a full FIFO never accepts.
  assign push_s = txfifo_downstream_valid & ~full_s;

  lpif_ll_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_wr),
    .rst_n (rst_wr_n),
    .push  (push_s),
    .wdata (txfifo_downstream_data),
    .pop   (pop_s),
    .head  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign txfifo_downstream_ready = ~full_s;
  assign tx_fifo_afull           = (count_s >= CW'(AFULL_LVL));
  assign tx_fifo_count           = count_s;
  assign tx_phy_data             = data_r;
  assign tx_phy_valid            = valid_r;
  assign tx_phy_mark             = mark_r;
  assign tx_overflow             = overflow_r;

  // Gearbox state register.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state_r <= ST_OFF;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state: start a word only when online with data; ST_HI always exits.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_OFF: begin
        if (tx_online) begin
          next_state_s = ST_LO;
        end else begin
          next_state_s = ST_OFF;
        end
      end
      ST_LO: begin
        if (!tx_online) begin
          next_state_s = ST_OFF;
        end else if (!empty_s) begin
          next_state_s = ST_HI;
        end else begin
          next_state_s = ST_LO;
        end
      end
      ST_HI: begin
        if (tx_online) begin
          next_state_s = ST_LO;
        end else begin
          next_state_s = ST_OFF;
        end
      end
      default: next_state_s = ST_OFF;
    endcase
  end

  // Output decode: half-select mux and head pop on the second beat.
  always_comb begin
    data_nxt_s  = {HALF_W{1'b0}};
    valid_nxt_s = 1'b0;
    mark_nxt_s  = 1'b0;
    pop_s       = 1'b0;
    case (state_r)
      ST_LO: begin
        if (tx_online && !empty_s) begin
          data_nxt_s  = head_s[HALF_W-1:0];
          valid_nxt_s = 1'b1;
          mark_nxt_s  = 1'b1;
        end else begin
          data_nxt_s  = {HALF_W{1'b0}};
          valid_nxt_s = 1'b0;
        end
      end
      ST_HI: begin
        data_nxt_s  = head_s[DATA_W-1:HALF_W];
        valid_nxt_s = 1'b1;
        mark_nxt_s  = 1'b0;
        pop_s       = 1'b1;
      end
      default: begin
        data_nxt_s  = {HALF_W{1'b0}};
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // PHY-facing output registers; idle beats carry zero data.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      data_r  <= {HALF_W{1'b0}};
      valid_r <= 1'b0;
      mark_r  <= 1'b0;
    end else begin
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      mark_r  <= mark_nxt_s;
    end
  end

  // Sticky overflow: any offered word that could not be accepted.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      overflow_r <= 1'b0;
    end else if (txfifo_downstream_valid && full_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

endmodule

// File: tb/tb_lpif_ll_tx_gearbox_x8_asym2.sv
// Self-checking bench for the x8 asym2 logic-link TX gearbox. A queue-based
// reference model predicts the full output vector after every clock edge.
module tb_lpif_ll_tx_gearbox_x8_asym2;

  localparam int W  = 580;
  localparam int HW = 290;
  localparam int OW = HW + 1 + 1 + 4 + 1 + 1 + 1;

  logic          clk_wr = 1'b0;
  logic          rst_wr_n;
  logic          tx_online;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          din_ready;
  logic          afull;
  logic [3:0]    count;
  logic [HW-1:0] phy_data;
  logic          phy_valid;
  logic          phy_mark;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // reference model state
  logic [W-1:0]  q[$];
  bit            m_hi;
  bit            m_armed;
  bit            m_ovf;
  logic [HW-1:0] m_data;
  bit            m_valid;
  bit            m_mark;

  lpif_ll_tx_gearbox_x8_asym2 dut (
    .clk_wr                  (clk_wr),
    .rst_wr_n                (rst_wr_n),
    .tx_online               (tx_online),
    .txfifo_downstream_data  (din),
    .txfifo_downstream_valid (din_valid),
    .txfifo_downstream_ready (din_ready),
    .tx_fifo_afull           (afull),
    .tx_fifo_count           (count),
    .tx_phy_data             (phy_data),
    .tx_phy_valid            (phy_valid),
    .tx_phy_mark             (phy_mark),
    .tx_overflow             (overflow)
  );

  always #5 clk_wr = ~clk_wr;

  wire [OW-1:0] obs = {phy_data, phy_valid, phy_mark, count, din_ready, afull, overflow};

  function automatic logic [OW-1:0] exp_vec();
    return {m_data, 1'(m_valid), 1'(m_mark), 4'(q.size()),
            1'(q.size() < 8), 1'(q.size() >= 6), 1'(m_ovf)};
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w = '0;
    for (int i = 0; i < 19; i++) w = {w[W-33:0], 32'($urandom())};
    return w;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_hi = 0; m_armed = 0; m_ovf = 0;
    m_data = '0; m_valid = 0; m_mark = 0;
  endfunction

  // One clock edge of the reference behaviour: emit from the pre-edge queue,
  // then accept the offered word if the pre-edge occupancy allowed it.
  function automatic void model_edge();
    bit rdy = (q.size() < 8);
    if (din_valid && !rdy) m_ovf = 1;
    if (m_hi) begin
      m_data = q[0][W-1:HW]; m_valid = 1; m_mark = 0;
      void'(q.pop_front());
      m_hi = 0; m_armed = tx_online;
    end else if (m_armed && tx_online && q.size() > 0) begin
      m_data = q[0][HW-1:0]; m_valid = 1; m_mark = 1;
      m_hi = 1;
    end else begin
      m_data = '0; m_valid = 0; m_mark = 0;
      m_armed = tx_online;
    end
    if (din_valid && rdy) q.push_back(din);
  endfunction

  task automatic tick();
    @(posedge clk_wr);
    model_edge();
    cyc++;
    @(negedge clk_wr);
  endtask

  task automatic test_reset();
    rst_wr_n = 1'b0; tx_online = 1'b0; din = '0; din_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_wr);
    n_checks++;
    if (obs !== exp_vec()) begin
      n_errors++; $display("FAIL reset: got %h expected %h", obs, exp_vec());
    end
    n_checks++;
    if (din_ready !== 1'b1 || count !== 4'd0) begin
      n_errors++; $display("FAIL reset_ready: ready %b count %0d expected 1 0", din_ready, count);
    end
    rst_wr_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    logic [HW-1:0] lo = {2'b01, {72{4'h1}}};
    logic [HW-1:0] hi = {2'b10, {72{4'h2}}};
    logic [HW-1:0] want [3];
    logic          wmark [3];
    want[0] = lo; want[1] = hi; want[2] = '0;
    wmark[0] = 1'b1; wmark[1] = 1'b0; wmark[2] = 1'b0;
    tx_online = 1'b1;
    tick();
    din = {hi, lo}; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (phy_data !== want[i] || phy_mark !== wmark[i] || phy_valid !== (i < 2)) begin
        n_errors++;
        $display("FAIL single_word beat %0d: got v%b m%b %h expected m%b %h",
                 i, phy_valid, phy_mark, phy_data, wmark[i], want[i]);
      end
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL single_word_model cyc %0d: got %h expected %h", cyc, obs, exp_vec());
      end
    end
  endtask

  task automatic test_fill_offline();
    tx_online = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      din = rand_word(); din_valid = 1'b1;
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL fill_offline cyc %0d: got %h expected %h", cyc, obs, exp_vec());
      end
    end
    din_valid = 1'b0;
    n_checks++;
    if (count !== 4'd8 || din_ready !== 1'b0 || afull !== 1'b1 || overflow !== 1'b1 || phy_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL fill_full: count %0d ready %b afull %b ovf %b valid %b expected 8 0 1 1 0",
               count, din_ready, afull, overflow, phy_valid);
    end
  endtask

  task automatic test_back_to_back();
    int beats = 0;
    tx_online = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din = rand_word(); din_valid = (i % 2 == 1);
      tick();
      if (phy_valid === 1'b1 && i <= 16) beats++;
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL back_to_back cyc %0d: got %h expected %h", cyc, obs, exp_vec());
      end
    end
    din_valid = 1'b0;
    n_checks++;
    if (beats != 16) begin
      n_errors++; $display("FAIL back_to_back_beats: got %0d expected 16", beats);
    end
  endtask

  task automatic test_offline_mid_word();
    int k;
    tx_online = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = rand_word(); din_valid = 1'b1;
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL offline_fill cyc %0d: got %h expected %h", cyc, obs, exp_vec());
      end
    end
    din_valid = 1'b0;
    for (k = 0; k < 10 && !m_hi; k++) tick();
    n_checks++;
    if (!m_hi || phy_mark !== 1'b1) begin
      n_errors++; $display("FAIL offline_wait: mark %b expected low half pending", phy_mark);
    end
    tx_online = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL offline_mid_word cyc %0d: got %h expected %h", cyc, obs, exp_vec());
      end
    end
    n_checks++;
    if (count === 4'd0 || phy_valid !== 1'b0) begin
      n_errors++; $display("FAIL offline_retain: count %0d valid %b expected >0 0", count, phy_valid);
    end
    tx_online = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL reonline cyc %0d: got %h expected %h", cyc, obs, exp_vec());
      end
    end
  endtask

  task automatic test_full_push_pop();
    tx_online = 1'b0;
    for (int k = 0; k < 12 && q.size() < 8; k++) begin
      din = rand_word(); din_valid = 1'b1;
      tick();
    end
    tx_online = 1'b1;
    for (int i = 0; i < 12; i++) begin
      din = rand_word(); din_valid = 1'b1;
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL full_push_pop cyc %0d: got %h expected %h", cyc, obs, exp_vec());
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    tx_online = 1'b1;
    din = rand_word(); din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int k = 0; k < 10 && !m_hi; k++) tick();
    #2 rst_wr_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (obs !== exp_vec()) begin
      n_errors++; $display("FAIL reset_mid_word: got %h expected %h", obs, exp_vec());
    end
    @(negedge clk_wr);
    rst_wr_n = 1'b1;
    tx_online = 1'b0;
    tick();
    tx_online = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = rand_word(); din_valid = (i == 1);
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL after_reset cyc %0d: got %h expected %h", cyc, obs, exp_vec());
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      din       = rand_word();
      din_valid = ($urandom_range(0, 99) < 55);
      tx_online = ($urandom_range(0, 99) < 85);
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++; $display("FAIL random cyc %0d: got %h expected %h", cyc, obs, exp_vec());
      end
    end
    din_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill_offline();
    test_back_to_back();
    test_offline_mid_word();
    test_full_push_pop();
    test_reset_mid_word();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
